// File: rtl/data_sram_responder_pkg.sv
// Shared encodings and helpers for the data-SRAM responder.
// Covers the access-size codes, the response queue entry layout and the alignment check.
package data_sram_responder_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // Queue entry layout: {is_load, data[31:0]}
    localparam int ENTRY_W = 33;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == SIZE_H) && addr_lo[0])
            || ((size == SIZE_W) && (addr_lo != 2'b00))
            || (size == 2'd3);
    endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// Request/response bus between the memory-access stage (master) and the data SRAM (slave).
interface data_sram_responder_if;

    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_stall;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        err_misalign;

    modport master (
        output req, wr, size, wstrb, addr, wdata, addr_stall,
        input  addr_ok, data_ok, rdata, err_misalign
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata, addr_stall,
        output addr_ok, data_ok, rdata, err_misalign
    );

endinterface

// File: rtl/data_sram_responder_queue.sv
// In-order response queue: a circular buffer whose entries each carry a latency countdown.
// The head is ready once its countdown reaches zero.
module sram_resp_queue
    import data_sram_responder_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int LATENCY = 1,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_entry,
    input  logic               pop,
    output logic               head_ready,
    output logic [ENTRY_W-1:0] head_entry,
    output logic [CNT_W-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ENTRY_W-1:0] entry_q [DEPTH];
    logic [1:0]         cd_q    [DEPTH];
    logic [DEPTH-1:0]   valid_q;
    logic [PTR_W-1:0]   head_q;
    logic [PTR_W-1:0]   tail_q;
    logic [CNT_W-1:0]   count_q;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // When the queue is full, push and pop can target the same slot.
    // The push is applied last in this block, so the new entry wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
                cd_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && (cd_q[i] != 2'd0)) begin
                    cd_q[i] <= cd_q[i] - 2'd1;
                end
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= ptr_next(head_q);
            end
            if (push) begin
                valid_q[tail_q] <= 1'b1;
                entry_q[tail_q] <= push_entry;
                cd_q[tail_q]    <= 2'(LATENCY - 1);
                tail_q          <= ptr_next(tail_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_ready = valid_q[head_q] && (cd_q[head_q] == 2'd0);
    assign head_entry = entry_q[head_q];
    assign count      = count_q;

endmodule

// File: rtl/data_sram_responder.sv
// Data-SRAM slave used as the data-memory model on the FPGA/sim top.
// Stores commit when accepted; responses come back in order after a fixed latency.
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int ADDR_WIDTH      = 12,
    parameter int LATENCY         = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    data_sram_responder_if.slave bus
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]           mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  accept;
    logic                  data_ok;
    logic [CNT_W-1:0]      count;
    logic [ENTRY_W-1:0]    push_entry;
    logic [ENTRY_W-1:0]    head_entry;
    logic [31:0]           rdata_last;
    logic [31:0]           rdata;
    logic                  err_q;
    logic                  unused_addr_hi;

    assign word_idx       = bus.addr[ADDR_WIDTH+1:2];
    assign unused_addr_hi = ^bus.addr[31:ADDR_WIDTH+2];

    // A response retiring this cycle frees its slot for the request arriving in the same cycle.
    assign bus.addr_ok = bus.req & ~bus.addr_stall
                       & ((count < CNT_W'(MAX_OUTSTANDING)) | data_ok);
    assign accept      = bus.req & bus.addr_ok;

    // Loads capture the pre-edge word, so a later store cannot disturb an accepted load.
    assign push_entry = {~bus.wr, mem[word_idx]};

    sram_resp_queue #(
        .DEPTH   (MAX_OUTSTANDING),
        .LATENCY (LATENCY)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (accept),
        .push_entry (push_entry),
        .pop        (data_ok),
        .head_ready (data_ok),
        .head_entry (head_entry),
        .count      (count)
    );

    always_ff @(posedge clk) begin
        if (!rst && accept && bus.wr) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.wstrb[b]) begin
                    mem[word_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = data_ok ? (head_entry[32] ? head_entry[31:0] : 32'h0) : rdata_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_last <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            if (data_ok) begin
                rdata_last <= rdata;
            end
            if (accept && is_misaligned(bus.size, bus.addr[1:0])) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.data_ok      = data_ok;
    assign bus.rdata        = rdata;
    assign bus.err_misalign = err_q;

    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        count <= CNT_W'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: one instance at LATENCY=1 and one at LATENCY=3.
module tb_data_sram_responder;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    data_sram_responder_if if1 ();
    data_sram_responder_if if3 ();

    data_sram_responder #(.ADDR_WIDTH(12), .LATENCY(1), .MAX_OUTSTANDING(2))
        dut1 (.clk(clk), .rst(rst), .bus(if1));
    data_sram_responder #(.ADDR_WIDTH(12), .LATENCY(3), .MAX_OUTSTANDING(2))
        dut3 (.clk(clk), .rst(rst), .bus(if3));

    task automatic idle_all();
        if1.req = 0; if1.wr = 0; if1.size = 2; if1.wstrb = 0;
        if1.addr = 0; if1.wdata = 0; if1.addr_stall = 0;
        if3.req = 0; if3.wr = 0; if3.size = 2; if3.wstrb = 0;
        if3.addr = 0; if3.wdata = 0; if3.addr_stall = 0;
    endtask

    // One-cycle request on dut1; returns at accept-edge + 1.
    task automatic issue1(input logic w, input logic [1:0] sz, input logic [3:0] st,
                          input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        if1.req = 1; if1.wr = w; if1.size = sz; if1.wstrb = st; if1.addr = a; if1.wdata = d;
        @(posedge clk); #1;
        if1.req = 0; if1.wr = 0;
    endtask

    task automatic issue3(input logic w, input logic [1:0] sz, input logic [3:0] st,
                          input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        if3.req = 1; if3.wr = w; if3.size = sz; if3.wstrb = st; if3.addr = a; if3.wdata = d;
        @(posedge clk); #1;
        if3.req = 0; if3.wr = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++; if (if1.data_ok !== 1'b0) begin miscompares++; $display("FAIL reset_data_ok: got %b want 0", if1.data_ok); end
        vectors++; if (if1.rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h want 00000000", if1.rdata); end
        vectors++; if (if1.err_misalign !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", if1.err_misalign); end
        vectors++; if (if3.addr_ok !== 1'b0) begin miscompares++; $display("FAIL reset_addr_ok: got %b want 0", if3.addr_ok); end
        rst = 0;
    endtask

    task automatic test_store_load();
        @(posedge clk); #1;
        if1.req = 1; if1.wr = 1; if1.size = 2; if1.wstrb = 4'hF; if1.addr = 32'h10; if1.wdata = 32'hDEADBEEF;
        @(negedge clk);
        vectors++; if (if1.addr_ok !== 1'b1) begin miscompares++; $display("FAIL sl_addr_ok: got %b want 1", if1.addr_ok); end
        @(posedge clk); #1;
        if1.wr = 0; if1.wstrb = 0;
        @(negedge clk);
        vectors++; if (if1.data_ok !== 1'b1) begin miscompares++; $display("FAIL sl_store_rsp: got %b want 1", if1.data_ok); end
        vectors++; if (if1.rdata !== 32'h0) begin miscompares++; $display("FAIL sl_store_rdata: got %h want 00000000", if1.rdata); end
        @(posedge clk); #1;
        if1.req = 0;
        @(negedge clk);
        vectors++; if (if1.data_ok !== 1'b1) begin miscompares++; $display("FAIL sl_load_rsp: got %b want 1", if1.data_ok); end
        vectors++; if (if1.rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL sl_load_rdata: got %h want deadbeef", if1.rdata); end
        @(negedge clk);
        vectors++; if (if1.data_ok !== 1'b0) begin miscompares++; $display("FAIL sl_pulse: got %b want 0", if1.data_ok); end
        vectors++; if (if1.rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL sl_hold: got %h want deadbeef", if1.rdata); end
    endtask

    task automatic test_partial_strobe();
        issue1(1, 2, 4'hF, 32'h20, 32'h11223344);
        issue1(1, 2, 4'b0101, 32'h20, 32'hAABBCCDD);
        issue1(1, 2, 4'h0, 32'h20, 32'hFFFFFFFF);
        @(negedge clk);
        vectors++; if (if1.data_ok !== 1'b1) begin miscompares++; $display("FAIL ps_zero_strb_rsp: got %b want 1", if1.data_ok); end
        issue1(0, 2, 4'h0, 32'h20, 32'h0);
        @(negedge clk);
        vectors++; if (if1.data_ok !== 1'b1) begin miscompares++; $display("FAIL ps_load_rsp: got %b want 1", if1.data_ok); end
        vectors++; if (if1.rdata !== 32'h11BB33DD) begin miscompares++; $display("FAIL ps_rdata: got %h want 11bb33dd", if1.rdata); end
    endtask

    task automatic test_outstanding();
        logic [6:0] exp_ok;
        logic [6:0] exp_dv;
        logic       acc;
        int         idx = 0;
        int         rsp = 0;
        exp_ok = 7'b1011011;   // bit c = cycle c
        exp_dv = 7'b1011000;
        for (int i = 0; i < 4; i++) issue3(1, 2, 4'hF, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
        repeat (6) @(posedge clk);
        #1;
        if3.req = 1; if3.wr = 0; if3.size = 2; if3.addr = 32'h100;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            vectors++; if (if3.addr_ok !== exp_ok[c]) begin miscompares++; $display("FAIL os_addr_ok c%0d: got %b want %b", c, if3.addr_ok, exp_ok[c]); end
            vectors++; if (if3.data_ok !== exp_dv[c]) begin miscompares++; $display("FAIL os_data_ok c%0d: got %b want %b", c, if3.data_ok, exp_dv[c]); end
            if (exp_dv[c]) begin
                vectors++; if (if3.rdata !== 32'hA0 + 32'(rsp)) begin miscompares++; $display("FAIL os_order c%0d: got %h want %h", c, if3.rdata, 32'hA0 + 32'(rsp)); end
                rsp++;
            end
            if (c == 6) begin
                if3.req = 0;
            end else begin
                acc = if3.addr_ok;
                @(posedge clk); #1;
                if (acc) idx++;
                if3.addr = 32'h100 + 32'(4 * idx);
            end
        end
        @(negedge clk);
        vectors++; if (if3.data_ok !== 1'b1) begin miscompares++; $display("FAIL os_last_rsp: got %b want 1", if3.data_ok); end
        vectors++; if (if3.rdata !== 32'hA3) begin miscompares++; $display("FAIL os_last_rdata: got %h want 000000a3", if3.rdata); end
        @(negedge clk);
        vectors++; if (if3.data_ok !== 1'b0) begin miscompares++; $display("FAIL os_empty: got %b want 0", if3.data_ok); end
    endtask

    task automatic test_load_vs_store();
        bit found = 0;
        issue3(1, 2, 4'hF, 32'h30, 32'h5);
        repeat (5) @(posedge clk);
        #1;
        if3.req = 1; if3.wr = 0; if3.size = 2; if3.addr = 32'h30;
        @(posedge clk); #1;
        if3.wr = 1; if3.wstrb = 4'hF; if3.wdata = 32'h9;
        @(posedge clk); #1;
        if3.req = 0; if3.wr = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (if3.data_ok) found = 1;
        end
        vectors++;
        if (!found) begin
            miscompares++; $display("FAIL lvs_timeout: got no data_ok want data_ok within 8 cycles");
        end else if (if3.rdata !== 32'h5) begin
            miscompares++; $display("FAIL lvs_rdata: got %h want 00000005", if3.rdata);
        end
        repeat (5) @(posedge clk);
        issue3(0, 2, 4'h0, 32'h30, 32'h0);
        repeat (3) @(negedge clk);
        vectors++; if (if3.data_ok !== 1'b1) begin miscompares++; $display("FAIL lvs_reload_rsp: got %b want 1", if3.data_ok); end
        vectors++; if (if3.rdata !== 32'h9) begin miscompares++; $display("FAIL lvs_reload_rdata: got %h want 00000009", if3.rdata); end
    endtask

    task automatic test_stall();
        @(posedge clk); #1;
        if1.req = 1; if1.wr = 0; if1.size = 2; if1.addr = 32'h10; if1.addr_stall = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++; if (if1.addr_ok !== 1'b0) begin miscompares++; $display("FAIL st_addr_ok %0d: got %b want 0", i, if1.addr_ok); end
            vectors++; if (if1.data_ok !== 1'b0) begin miscompares++; $display("FAIL st_data_ok %0d: got %b want 0", i, if1.data_ok); end
            @(posedge clk); #1;
        end
        if1.addr_stall = 0;
        @(negedge clk);
        vectors++; if (if1.addr_ok !== 1'b1) begin miscompares++; $display("FAIL st_release: got %b want 1", if1.addr_ok); end
        @(posedge clk); #1;
        if1.req = 0;
        @(negedge clk);
        vectors++; if (if1.data_ok !== 1'b1) begin miscompares++; $display("FAIL st_rsp: got %b want 1", if1.data_ok); end
        vectors++; if (if1.rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL st_rdata: got %h want deadbeef", if1.rdata); end
    endtask

    task automatic test_misalign_reset();
        @(negedge clk);
        vectors++; if (if1.err_misalign !== 1'b0) begin miscompares++; $display("FAIL ma_pre: got %b want 0", if1.err_misalign); end
        issue1(0, 2, 4'h0, 32'h42, 32'h0);
        @(negedge clk);
        vectors++; if (if1.err_misalign !== 1'b1) begin miscompares++; $display("FAIL ma_set: got %b want 1", if1.err_misalign); end
        repeat (4) @(negedge clk);
        vectors++; if (if1.err_misalign !== 1'b1) begin miscompares++; $display("FAIL ma_sticky: got %b want 1", if1.err_misalign); end
        @(posedge clk); #1;
        if3.req = 1; if3.wr = 0; if3.size = 1; if3.addr = 32'h43;
        @(posedge clk); #1;
        if3.size = 2; if3.addr = 32'h10;
        @(posedge clk); #1;
        if3.req = 0;
        @(negedge clk);
        vectors++; if (if3.err_misalign !== 1'b1) begin miscompares++; $display("FAIL ma_half: got %b want 1", if3.err_misalign); end
        #1 rst = 1;
        #1;
        vectors++; if (if3.data_ok !== 1'b0) begin miscompares++; $display("FAIL rst_data_ok: got %b want 0", if3.data_ok); end
        vectors++; if (if3.err_misalign !== 1'b0) begin miscompares++; $display("FAIL rst_err3: got %b want 0", if3.err_misalign); end
        vectors++; if (if1.err_misalign !== 1'b0) begin miscompares++; $display("FAIL rst_err1: got %b want 0", if1.err_misalign); end
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++; if (if3.data_ok !== 1'b0) begin miscompares++; $display("FAIL rst_drop %0d: got %b want 0", i, if3.data_ok); end
        end
        issue1(0, 2, 4'h0, 32'h10, 32'h0);
        @(negedge clk);
        vectors++; if (if1.data_ok !== 1'b1) begin miscompares++; $display("FAIL rst_mem_rsp: got %b want 1", if1.data_ok); end
        vectors++; if (if1.rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rst_mem_rdata: got %h want deadbeef", if1.rdata); end
        issue1(0, 3, 4'h0, 32'h10, 32'h0);
        @(negedge clk);
        vectors++; if (if1.err_misalign !== 1'b1) begin miscompares++; $display("FAIL ma_size3: got %b want 1", if1.err_misalign); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_store_load();
        test_partial_strobe();
        test_outstanding();
        test_load_vs_store();
        test_stall();
        test_misalign_reset();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Slave end of the data-SRAM request/response interface that the memory-access stage reads from; serves loads and stores issued by the execute stage.
- Used as the data-memory model on the FPGA/simulation top.
- Accepts at most one request per cycle.
- Commits stores at acceptance and returns responses in order after a fixed latency.
- Supports injected address-phase back-pressure so pipeline stall paths can be exercised.

Parameters:
- ADDR_WIDTH, 12, number of word-index bits; memory holds 2^ADDR_WIDTH 32-bit words.
- LATENCY, 1, cycles from acceptance edge to data_ok; legal range 1..4.
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered requests; legal range 1..4.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- req  input  1  request valid
- wr  input  1  1 = store, 0 = load
- size  input  2  0 = byte, 1 = half, 2 = word; 3 is reserved
- wstrb  input  4  byte write enables; authoritative for stores
- addr  input  32  byte address
- wdata  input  32  store data
- addr_stall  input  1  test hook; forces addr_ok low
- addr_ok  output  1  request accepted this cycle (combinational)
- data_ok  output  1  response valid, single-cycle pulse
- rdata  output  32  load data, full word
- err_misalign  output  1  sticky misaligned-access flag

Behaviour:
- Async reset:
  - data_ok=0, rdata=0, err_misalign=0.
  - Response queue emptied, outstanding count=0.
  - Memory array is NOT reset.
  - Reset asserted mid-operation drops all pending responses; no data_ok until new requests are accepted after deassert.
- addr_ok = req & ~addr_stall & (count < MAX_OUTSTANDING | data_ok).
  - A response retiring this cycle frees its slot in the same cycle.
- Acceptance = req & addr_ok at a rising edge.
- Word index = addr[ADDR_WIDTH+1:2]; higher address bits ignored (aliasing).
- Store:
  - At the acceptance edge, each byte i is written where wstrb[i]=1.
  - wstrb=0 is legal; no write occurs, but a response is still generated.
- Load:
  - Word is sampled at the acceptance edge and held in the queue entry.
  - A store accepted later never alters an already-accepted load.
  - A load accepted one edge after a store to the same word sees the new data.
- Every accepted request, load or store, enqueues one entry: {is_load, data, countdown=LATENCY-1}.
- Each cycle, the countdown of every valid entry decrements, saturating at 0.
- data_ok=1 in a cycle iff the head entry exists and its countdown is 0.
  - Head is popped at the following edge; there is no data-phase back-pressure.
  - LATENCY=1: request accepted at edge E gives data_ok in the cycle after E.
- Order: strictly in acceptance order, at most one data_ok per cycle.
  - Back-to-back accepts yield back-to-back data_ok pulses.
- rdata:
  - Registered; valid only while data_ok=1.
  - Equals the captured word for loads, 32'h0 for stores.
  - Holds its last value otherwise.
- Simultaneous accept and retire: count unchanged; enqueue and pop both occur.
- Full queue (count=MAX_OUTSTANDING, no retire): addr_ok=0.
- Empty queue: data_ok=0.
- err_misalign is set at acceptance when any of these hold:
  - size=1 and addr[0]=1
  - size=2 and addr[1:0]≠0
  - size=3
- err_misalign is cleared only by reset; the access is still performed.
- count is the outstanding counter, width clog2(MAX_OUTSTANDING+1); it must never exceed MAX_OUTSTANDING (assertion).

Decomposition:
- Shared package holds:
  - size encodings SIZE_B=0, SIZE_H=1, SIZE_W=2
  - queue entry width constant
  - misalign check function
- Sub-module sram_resp_queue: circular buffer of MAX_OUTSTANDING entries with per-entry countdown, head/tail pointers (wrapping modulo depth), count, and push/pop ports.
- The top contains the memory array, acceptance logic, strobe merge and error flag.

Test Plan:
- Reset, then LATENCY=1. Store addr=0x10, wdata=0xDEADBEEF, wstrb=4'hF; load addr=0x10 on the next cycle. Expected: data_ok pulses on two consecutive cycles, second with rdata=0xDEADBEEF.
- Partial strobe: word 0x20 holds 0x11223344; store wstrb=4'b0101, wdata=0xAABBCCDD. Expected: a subsequent load returns 0x11BB33DD.
- LATENCY=3, MAX_OUTSTANDING=2: hold req high with loads every cycle. Expected:
  - addr_ok drops on the 3rd request until the first data_ok, then recovers in that same cycle.
  - data_ok pulses arrive in order.
- Load word 0x30=0x5 accepted, then store 0x9 to 0x30 while the load is pending. Expected: load response rdata=0x5.
- addr_stall=1 for 3 cycles with req=1. Expected: addr_ok=0, no data_ok; after release, one accept and a response 1 cycle later.
- Load with size=2, addr=0x42. Expected: err_misalign=1 and stays 1. Assert rst with 2 requests pending. Expected: data_ok=0 and err_misalign=0 immediately; memory contents preserved (reload 0x10 → 0xDEADBEEF).
